// File: rtl/mem_arb_pkg.sv
// Shared types for the RAM bus arbiter.
// Sequencer states, owner tags, latency counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VGA = 1'b1
  } arb_owner_e;

  // Wide enough to count MEM_LATENCY-1 for latencies up to 3.
  localparam int LAT_W = 2;

endpackage

// File: rtl/arb_priority_sel.sv
// Winner pick for the RAM arbiter: VGA first, CPU
// forced in after MAX_VGA_STREAK back-to-back VGA grants.
module arb_priority_sel #(
  parameter int MAX_VGA_STREAK = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cpu_req,
  input  logic vga_req,
  input  logic sample,
  input  logic hold_cpu,
  input  logic hold_vga,
  output logic grant_cpu,
  output logic grant_vga
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_VGA_STREAK);

  logic [3:0] streak_q, streak_d;
  logic       pick_cpu, pick_vga;

  // A requester whose ack is pulsing is still holding
  // its old request, so its pick is deferred a cycle.
  always_comb begin
    pick_vga  = vga_req & ~(cpu_req & (streak_q == STREAK_MAX));
    pick_cpu  = cpu_req & ~pick_vga;
    grant_vga = sample & pick_vga & ~hold_vga;
    grant_cpu = sample & pick_cpu & ~hold_cpu;
  end

  // Count VGA grants that made the CPU wait.
  always_comb begin
    streak_d = streak_q;
    if (sample) begin
      if (!cpu_req || grant_cpu) begin
        streak_d = '0;
      end else if (grant_vga && streak_q < STREAK_MAX) begin
        streak_d = streak_q + 4'd1;
      end
    end
  end

  // Streak register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single-port RAM between the CPU and the
// VGA fetcher: IDLE -> ISSUE -> WAIT, one access at a time.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int MEM_LATENCY    = 1,
  parameter int MAX_VGA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_rdy,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              vga_ack_q, vga_ack_d;
  logic              sample;
  logic              grant_cpu, grant_vga;
  logic              lat_last;

  assign sample   = (state_q == ARB_IDLE);
  assign lat_last = (lat_q == LAT_W'(MEM_LATENCY - 1));

  arb_priority_sel #(
    .MAX_VGA_STREAK (MAX_VGA_STREAK)
  ) u_sel (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .vga_req   (vga_req),
    .sample    (sample),
    .hold_cpu  (cpu_ack_q),
    .hold_vga  (vga_ack_q),
    .grant_cpu (grant_cpu),
    .grant_vga (grant_vga)
  );

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: grant, one strobe cycle, then latency wait.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (grant_cpu || grant_vga) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT:  if (lat_last) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Access latch, latency counter, read capture and acks.
  always_comb begin
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    cpu_rdata_d = cpu_rdata_q;
    vga_rdata_d = vga_rdata_q;
    cpu_ack_d   = 1'b0;
    vga_ack_d   = 1'b0;
    unique case (1'b1)
      grant_vga: begin
        owner_d = OWN_VGA;
        addr_d  = vga_addr;
        we_d    = 1'b0;
        wdata_d = '0;
      end
      grant_cpu: begin
        owner_d = OWN_CPU;
        addr_d  = cpu_addr;
        we_d    = cpu_we;
        wdata_d = cpu_wdata;
      end
      default: ;
    endcase
    if (state_q == ARB_ISSUE) begin
      lat_d = '0;
    end else if (state_q == ARB_WAIT && !lat_last) begin
      lat_d = lat_q + 1'b1;
    end
    if (state_q == ARB_WAIT && lat_last) begin
      if (owner_q == OWN_CPU) begin
        cpu_ack_d = 1'b1;
        if (!we_q) cpu_rdata_d = mem_rdata;
      end else begin
        vga_ack_d   = 1'b1;
        vga_rdata_d = mem_rdata;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q     <= OWN_CPU;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      lat_q       <= '0;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      vga_ack_q   <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      cpu_rdata_q <= cpu_rdata_d;
      vga_rdata_q <= vga_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      vga_ack_q   <= vga_ack_d;
    end
  end

  // RAM strobe only in ISSUE; bus parks at zero otherwise.
  always_comb begin
    mem_en    = (state_q == ARB_ISSUE);
    mem_we    = mem_en & we_q;
    mem_addr  = mem_en ? addr_q : '0;
    mem_wdata = mem_we ? wdata_q : '0;
  end

  assign cpu_rdata = cpu_rdata_q;
  assign vga_rdata = vga_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign vga_ack   = vga_ack_q;
  assign cpu_rdy   = ~cpu_req | cpu_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus
// random rounds checked against a transaction model.
module tb_mem_bus_arbiter;

  localparam int LAT  = 1;
  localparam int MAXS = 4;
  localparam int ACC  = 2 + LAT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_rdy;
  logic        vga_req;
  logic [15:0] vga_addr;
  logic [7:0]  vga_rdata;
  logic        vga_ack;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W         (16),
    .DATA_W         (8),
    .MEM_LATENCY    (LAT),
    .MAX_VGA_STREAK (MAXS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdy   (cpu_rdy),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .vga_rdata (vga_rdata),
    .vga_ack   (vga_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // RAM with a backdoor port for preloading.
  logic [7:0]  ram [65536];
  logic [7:0]  pipe [LAT];
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr]
                                   : 8'($urandom);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } acc_t;

  acc_t        en_q[$];
  logic [7:0]  ref_ram [logic [15:0]];
  int          cyc;
  int          cpu_acks, vga_acks;
  int          cpu_ack_cyc, vga_ack_cyc;
  logic        rdy_at_ack;
  int          rdy_bad;
  bit          cpu_hold, vga_hold;
  logic [7:0]  exp_cpu, exp_vga;
  int          vectors, miscompares;

  // Advance to the next falling edge and log bus events.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (mem_en)
      en_q.push_back('{cyc, mem_addr, mem_we, mem_wdata});
    if (cpu_rdy !== (!cpu_req || cpu_ack)) rdy_bad++;
    if (cpu_ack) begin
      cpu_acks++;
      cpu_ack_cyc = cyc;
      rdy_at_ack  = cpu_rdy;
      if (!cpu_hold) cpu_req = 1'b0;
    end
    if (vga_ack) begin
      vga_acks++;
      vga_ack_cyc = cyc;
      if (!vga_hold) vga_req = 1'b0;
    end
  endtask

  task automatic poke(input logic [15:0] a,
                      input logic [7:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    step();
    bd_we   = 1'b0;
    ref_ram[a] = d;
  endtask

  task automatic clear_log();
    en_q.delete();
    cpu_acks = 0;
    vga_acks = 0;
    cpu_ack_cyc = -1;
    vga_ack_cyc = -1;
  endtask

  task automatic test_reset();
    int c0;
    poke(16'h0010, 8'h3C);
    clear_log();
    reset_n  = 1'b0;
    cpu_addr = 16'h0010;
    cpu_we   = 1'b0;
    cpu_req  = 1'b1;
    repeat (3) begin
      step();
      vectors++;
      if (mem_en !== 1'b0 || cpu_rdy !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_en_rdy: got %b%b want 00",
                 mem_en, cpu_rdy);
      end
      vectors++;
      if ({cpu_ack, vga_ack} !== 2'b00) begin
        miscompares++;
        $display("FAIL rst_acks: got %b%b want 00",
                 cpu_ack, vga_ack);
      end
    end
    vectors++;
    if ({cpu_rdata, vga_rdata} !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_rdata: got %h want 0000",
               {cpu_rdata, vga_rdata});
    end
    reset_n = 1'b1;
    c0 = cyc;
    step();
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0010) begin
      miscompares++;
      $display("FAIL rst_first_en: got %b/%h want 1/0010",
               mem_en, mem_addr);
    end
    repeat (ACC + 1) step();
    vectors++;
    if (cpu_acks !== 1 || cpu_ack_cyc !== c0 + ACC) begin
      miscompares++;
      $display("FAIL rst_ack: got %0d@%0d want 1@%0d",
               cpu_acks, cpu_ack_cyc, c0 + ACC);
    end
    vectors++;
    if (cpu_rdata !== 8'h3C) begin
      miscompares++;
      $display("FAIL rst_rd: got %h want 3c", cpu_rdata);
    end
    exp_cpu = 8'h3C;
    exp_vga = 8'h00;
  endtask

  task automatic test_cpu_read();
    int c0;
    int early_rdy;
    poke(16'h1234, 8'hA9);
    clear_log();
    early_rdy = 0;
    cpu_addr = 16'h1234;
    cpu_we   = 1'b0;
    cpu_req  = 1'b1;
    c0 = cyc;
    for (int k = 1; k <= ACC + 2; k++) begin
      step();
      if (k < ACC && cpu_rdy !== 1'b0) early_rdy++;
    end
    vectors++;
    if (en_q.size() !== 1) begin
      miscompares++;
      $display("FAIL rd_en_count: got %0d want 1",
               en_q.size());
    end else begin
      vectors++;
      if (en_q[0].addr !== 16'h1234 || en_q[0].we !== 1'b0
          || en_q[0].cyc !== c0 + 1) begin
        miscompares++;
        $display("FAIL rd_bus: got %h/%b@%0d want 1234/0@%0d",
                 en_q[0].addr, en_q[0].we, en_q[0].cyc, c0 + 1);
      end
    end
    vectors++;
    if (cpu_acks !== 1 || cpu_ack_cyc !== c0 + ACC) begin
      miscompares++;
      $display("FAIL rd_ack: got %0d@%0d want 1@%0d",
               cpu_acks, cpu_ack_cyc, c0 + ACC);
    end
    vectors++;
    if (cpu_rdata !== 8'hA9) begin
      miscompares++;
      $display("FAIL rd_data: got %h want a9", cpu_rdata);
    end
    vectors++;
    if (early_rdy !== 0 || rdy_at_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_rdy: got %0d/%b want 0/1",
               early_rdy, rdy_at_ack);
    end
    exp_cpu = 8'hA9;
  endtask

  task automatic test_cpu_write();
    int c0;
    clear_log();
    cpu_addr  = 16'h0200;
    cpu_wdata = 8'h5C;
    cpu_we    = 1'b1;
    cpu_req   = 1'b1;
    c0 = cyc;
    repeat (ACC + 2) step();
    vectors++;
    if (en_q.size() !== 1) begin
      miscompares++;
      $display("FAIL wr_en_count: got %0d want 1",
               en_q.size());
    end else begin
      vectors++;
      if (en_q[0].addr !== 16'h0200 || en_q[0].we !== 1'b1
          || en_q[0].wdata !== 8'h5C) begin
        miscompares++;
        $display("FAIL wr_bus: got %h/%b/%h want 0200/1/5c",
                 en_q[0].addr, en_q[0].we, en_q[0].wdata);
      end
    end
    vectors++;
    if (cpu_acks !== 1 || cpu_ack_cyc !== c0 + ACC) begin
      miscompares++;
      $display("FAIL wr_ack: got %0d@%0d want 1@%0d",
               cpu_acks, cpu_ack_cyc, c0 + ACC);
    end
    vectors++;
    if (vga_rdata !== exp_vga || cpu_rdata !== exp_cpu) begin
      miscompares++;
      $display("FAIL wr_rdata_kept: got %h/%h want %h/%h",
               cpu_rdata, vga_rdata, exp_cpu, exp_vga);
    end
    ref_ram[16'h0200] = 8'h5C;
    clear_log();
    cpu_we  = 1'b0;
    cpu_req = 1'b1;
    repeat (ACC + 2) step();
    vectors++;
    if (cpu_rdata !== ref_ram[16'h0200]) begin
      miscompares++;
      $display("FAIL wr_readback: got %h want %h",
               cpu_rdata, ref_ram[16'h0200]);
    end
    exp_cpu = ref_ram[16'h0200];
  endtask

  task automatic test_priority();
    int c0;
    poke(16'h0300, 8'h11);
    poke(16'h8100, 8'h22);
    clear_log();
    cpu_addr = 16'h0300;
    cpu_we   = 1'b0;
    vga_addr = 16'h8100;
    cpu_req  = 1'b1;
    vga_req  = 1'b1;
    c0 = cyc;
    repeat (2 * ACC + 2) step();
    vectors++;
    if (en_q.size() !== 2) begin
      miscompares++;
      $display("FAIL pri_en_count: got %0d want 2",
               en_q.size());
    end else begin
      vectors++;
      if (en_q[0].addr !== 16'h8100 || en_q[0].cyc !== c0 + 1
          || en_q[1].addr !== 16'h0300
          || en_q[1].cyc !== c0 + 1 + ACC) begin
        miscompares++;
        $display("FAIL pri_order: got %h@%0d,%h@%0d want 8100@%0d,0300@%0d",
                 en_q[0].addr, en_q[0].cyc, en_q[1].addr,
                 en_q[1].cyc, c0 + 1, c0 + 1 + ACC);
      end
    end
    vectors++;
    if (vga_ack_cyc !== c0 + ACC
        || cpu_ack_cyc !== c0 + 2 * ACC) begin
      miscompares++;
      $display("FAIL pri_acks: got %0d,%0d want %0d,%0d",
               vga_ack_cyc, cpu_ack_cyc, c0 + ACC, c0 + 2 * ACC);
    end
    vectors++;
    if (vga_rdata !== 8'h22 || cpu_rdata !== 8'h11) begin
      miscompares++;
      $display("FAIL pri_data: got %h/%h want 11/22",
               cpu_rdata, vga_rdata);
    end
    exp_cpu = 8'h11;
    exp_vga = 8'h22;
  endtask

  task automatic test_starvation();
    int n;
    int budget;
    bit want_cpu;
    n = 2 * (MAXS + 1);
    poke(16'h0400, 8'h33);
    poke(16'h8400, 8'h44);
    clear_log();
    cpu_hold = 1'b1;
    vga_hold = 1'b1;
    cpu_addr = 16'h0400;
    cpu_we   = 1'b0;
    vga_addr = 16'h8400;
    cpu_req  = 1'b1;
    vga_req  = 1'b1;
    budget = 0;
    while (en_q.size() < n && budget < 200) begin
      step();
      budget++;
    end
    vectors++;
    if (budget >= 200) begin
      miscompares++;
      $display("FAIL stv_timeout: got %0d grants want %0d",
               en_q.size(), n);
    end
    cpu_req  = 1'b0;
    vga_req  = 1'b0;
    cpu_hold = 1'b0;
    vga_hold = 1'b0;
    repeat (ACC + 3) step();
    vectors++;
    if (en_q.size() !== n) begin
      miscompares++;
      $display("FAIL stv_count: got %0d want %0d",
               en_q.size(), n);
    end
    for (int k = 0; k < n && k < en_q.size(); k++) begin
      want_cpu = (k % (MAXS + 1)) == MAXS;
      vectors++;
      if (en_q[k].addr[15] !== !want_cpu) begin
        miscompares++;
        $display("FAIL stv_grant%0d: got %s want %s", k,
                 en_q[k].addr[15] ? "V" : "C",
                 want_cpu ? "C" : "V");
      end
    end
    vectors++;
    if (cpu_rdata !== 8'h33 || vga_rdata !== 8'h44) begin
      miscompares++;
      $display("FAIL stv_data: got %h/%h want 33/44",
               cpu_rdata, vga_rdata);
    end
    exp_cpu = 8'h33;
    exp_vga = 8'h44;
  endtask

  task automatic test_random();
    int          c0, ci, seen;
    bit          c_en, v_en, cw, drop;
    logic [15:0] ca, va;
    logic [7:0]  cd, rc, rv;
    rdy_bad = 0;
    for (int r = 0; r < 20; r++) begin
      c_en = 1'($urandom);
      v_en = 1'($urandom);
      if (!c_en && !v_en) c_en = 1'b1;
      cw   = 1'($urandom);
      drop = 1'($urandom);
      ca   = {1'b0, 15'($urandom)};
      va   = {1'b1, 15'($urandom)};
      cd   = 8'($urandom);
      rc   = 8'($urandom);
      rv   = 8'($urandom);
      if (c_en && !cw) poke(ca, rc);
      if (v_en) poke(va, rv);
      clear_log();
      cpu_addr  = ca;
      cpu_we    = cw;
      cpu_wdata = cd;
      vga_addr  = va;
      cpu_req   = c_en;
      vga_req   = v_en;
      c0 = cyc;
      seen = 0;
      repeat (2 * ACC + 3) begin
        step();
        if (en_q.size() > seen) begin
          seen = en_q.size();
          if (en_q[seen-1].addr[15]) begin
            vga_addr = 16'($urandom);
          end else begin
            cpu_addr  = 16'($urandom);
            cpu_wdata = 8'($urandom);
            cpu_we    = 1'($urandom);
            if (drop) cpu_req = 1'b0;
          end
        end
      end
      ci = v_en ? 1 : 0;
      vectors++;
      if (en_q.size() !== int'(c_en) + int'(v_en)) begin
        miscompares++;
        $display("FAIL rnd%0d_count: got %0d want %0d", r,
                 en_q.size(), int'(c_en) + int'(v_en));
      end else begin
        vectors++;
        if (en_q[0].addr !== (v_en ? va : ca)
            || en_q[0].cyc !== c0 + 1) begin
          miscompares++;
          $display("FAIL rnd%0d_first: got %h@%0d want %h@%0d",
                   r, en_q[0].addr, en_q[0].cyc,
                   v_en ? va : ca, c0 + 1);
        end
        if (c_en) begin
          vectors++;
          if (en_q[ci].addr !== ca || en_q[ci].we !== cw
              || (cw && en_q[ci].wdata !== cd)
              || en_q[ci].cyc !== c0 + 1 + ci * ACC) begin
            miscompares++;
            $display("FAIL rnd%0d_cpu_bus: got %h/%b/%h@%0d want %h/%b/%h@%0d",
                     r, en_q[ci].addr, en_q[ci].we,
                     en_q[ci].wdata, en_q[ci].cyc,
                     ca, cw, cd, c0 + 1 + ci * ACC);
          end
        end
      end
      if (c_en) begin
        if (cw) ref_ram[ca] = cd;
        else    exp_cpu = ref_ram[ca];
      end
      if (v_en) exp_vga = ref_ram[va];
      vectors++;
      if (cpu_acks !== int'(c_en) || vga_acks !== int'(v_en)
          || (c_en && cpu_ack_cyc !== c0 + (ci + 1) * ACC)
          || (v_en && vga_ack_cyc !== c0 + ACC)) begin
        miscompares++;
        $display("FAIL rnd%0d_acks: got c%0d@%0d v%0d@%0d want c%0d v%0d",
                 r, cpu_acks, cpu_ack_cyc, vga_acks,
                 vga_ack_cyc, c_en, v_en);
      end
      vectors++;
      if (cpu_rdata !== exp_cpu || vga_rdata !== exp_vga) begin
        miscompares++;
        $display("FAIL rnd%0d_data: got %h/%h want %h/%h",
                 r, cpu_rdata, vga_rdata, exp_cpu, exp_vga);
      end
      cpu_req = 1'b0;
      vga_req = 1'b0;
      step();
    end
    vectors++;
    if (rdy_bad !== 0) begin
      miscompares++;
      $display("FAIL rnd_rdy: got %0d bad cycles want 0",
               rdy_bad);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    poke(16'h8200, 8'h66);
    poke(16'h0500, 8'h77);
    clear_log();
    vga_addr = 16'h8200;
    vga_req  = 1'b1;
    step();
    step();
    reset_n = 1'b0;
    #1;
    vectors++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_bus: got %b%b want 00", mem_en, mem_we);
    end
    vga_req = 1'b0;
    repeat (2) step();
    vectors++;
    if (vga_acks !== 0 || vga_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_noack: got %0d/%h want 0/00",
               vga_acks, vga_rdata);
    end
    reset_n  = 1'b1;
    cpu_addr = 16'h0500;
    cpu_we   = 1'b0;
    cpu_req  = 1'b1;
    c0 = cyc;
    repeat (ACC + 2) step();
    vectors++;
    if (cpu_ack_cyc !== c0 + ACC || cpu_rdata !== 8'h77
        || vga_acks !== 0) begin
      miscompares++;
      $display("FAIL mid_after: got %0d/%h/%0d want %0d/77/0",
               cpu_ack_cyc, cpu_rdata, vga_acks, c0 + ACC);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    vga_req   = 1'b0;
    vga_addr  = '0;
    bd_we     = 1'b0;
    bd_addr   = '0;
    bd_data   = '0;
    cpu_hold  = 1'b0;
    vga_hold  = 1'b0;
    cyc       = 0;
    rdy_bad   = 0;
    exp_cpu   = '0;
    exp_vga   = '0;
    vectors   = 0;
    miscompares = 0;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_priority();
    test_starvation();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
